// File: rtl/shr_host_pkg.sv
// Shared definitions for the scan-harness host: the FSM state encoding and
// the default vector widths.
package shr_host_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STROBE,
    S_CAPTURE
  } state_t;

  localparam int DIN_N_DEF  = 256;
  localparam int DOUT_N_DEF = 256;

endpackage

// File: rtl/shr_bit_counter.sv
// Loadable down-counter with a zero flag; load wins over decrement and the
// count saturates at zero rather than wrapping.
module shr_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shr_host.sv
// Scan-harness host: shifts a vector into the harness MSB first, strobes it,
// then captures the harness response serially into vec_out.
module shr_host
  import shr_host_pkg::*;
#(
  parameter int DIN_N  = DIN_N_DEF,
  parameter int DOUT_N = DOUT_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIN_N-1:0]  vec_in,
  output logic              busy,
  output logic              done,
  output logic [DOUT_N-1:0] vec_out,
  output logic              ser_di,
  output logic              ser_stb,
  input  logic              ser_do
);

  localparam int MAXN = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int CW   = $clog2(MAXN + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(DIN_N - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(DOUT_N - 1);

  state_t state, state_nxt;

  logic [DIN_N-1:0]  tx;
  logic [DOUT_N-1:0] rx;
  logic [DIN_N-1:0]  tx_shl;
  logic [DOUT_N:0]   rx_ext;
  logic [DOUT_N-1:0] rx_nxt;

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_dec;
  logic [CW-1:0] cnt;
  logic          cnt_zero;

  logic accept, shift_en, strobe_nxt, capture_en, finish;

  shr_bit_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // tx is consumed MSB first by shifting left; rx takes ser_do into bit 0.
  assign tx_shl = tx << 1;
  assign rx_ext = {rx, ser_do};
  assign rx_nxt = rx_ext[DOUT_N-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    accept     = 1'b0;
    shift_en   = 1'b0;
    strobe_nxt = 1'b0;
    capture_en = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !busy) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
          cnt_load  = 1'b1;
          cnt_val   = SHIFT_LAST;
        end
      end
      S_SHIFT: begin
        if (cnt_zero) begin
          state_nxt  = S_STROBE;
          strobe_nxt = 1'b1;
          cnt_load   = 1'b1;
        end else begin
          shift_en = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      S_STROBE: begin
        state_nxt = S_CAPTURE;
        cnt_load  = 1'b1;
        cnt_val   = CAP_LAST;
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        if (cnt_zero) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
          cnt_load  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: ser_di carries the bit for the coming cycle, so the
  // first bit is presented straight from vec_in on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      ser_stb <= 1'b0;
      ser_di  <= 1'b0;
      vec_out <= '0;
      tx      <= '0;
      rx      <= '0;
    end else begin
      done    <= finish;
      ser_stb <= strobe_nxt;
      if (accept)      busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      if (accept)        ser_di <= vec_in[DIN_N-1];
      else if (shift_en) ser_di <= tx_shl[DIN_N-1];
      else               ser_di <= 1'b0;
      if (accept)        tx <= vec_in;
      else if (shift_en) tx <= tx_shl;
      if (capture_en) rx <= rx_nxt;
      if (finish)     vec_out <= rx_nxt;
    end
  end

endmodule

// File: tb/tb_shr_host.sv
// Directed bench for shr_host with DIN_N=DOUT_N=8 against a behavioural scan
// harness whose response is either dout=din or dout=~din.
module tb_shr_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] vec_in;
  logic       busy, done, ser_di, ser_stb, ser_do;
  logic [7:0] vec_out;

  logic [7:0] din_shr  = 8'h00;
  logic [7:0] din      = 8'h00;
  logic [7:0] dout_shr = 8'h00;
  logic       roi_inv  = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shr_host #(.DIN_N(8), .DOUT_N(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .vec_in  (vec_in),
    .busy    (busy),
    .done    (done),
    .vec_out (vec_out),
    .ser_di  (ser_di),
    .ser_stb (ser_stb),
    .ser_do  (ser_do)
  );

  // Harness model: serial-in shift register, strobe latch, serial-out shift.
  always @(posedge clk) begin
    din_shr <= {din_shr[6:0], ser_di};
    if (ser_stb) begin
      din      <= din_shr;
      dout_shr <= roi_inv ? ~din : din;
    end else begin
      dout_shr <= {dout_shr[6:0], 1'b0};
    end
  end
  assign ser_do = dout_shr[7];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in "cycle 0"; returns in the done cycle so a following call starts
  // a back-to-back transaction.
  task automatic xfer(input logic [7:0] v, input logic [7:0] exp_out, input bit glitch);
    start  = 1'b1;
    vec_in = v;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      if (cyc == 1) start = 1'b0;
      if (glitch && cyc == 3) begin
        start  = 1'b1;
        vec_in = 8'hFF;
      end
      if (glitch && cyc == 4) start = 1'b0;
      check_eq($sformatf("di_c%0d_%h", cyc, v), ser_di, (cyc <= 8) ? v[8-cyc] : 1'b0);
      check_eq($sformatf("stb_c%0d_%h", cyc, v), ser_stb, cyc == 9);
      check_eq($sformatf("done_c%0d_%h", cyc, v), done, cyc == 18);
      check_eq($sformatf("busy_c%0d_%h", cyc, v), busy, cyc < 18);
    end
    check_eq($sformatf("vec_out_%h", v), vec_out, exp_out);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    vec_in = 8'h00;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_stb", ser_stb, 0);
    check_eq("rst_di", ser_di, 0);
    check_eq("rst_vec_out", vec_out, 0);

    // rst has priority over a simultaneous start
    start  = 1'b1;
    vec_in = 8'hFF;
    tick();
    check_eq("rst_prio_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();

    xfer(8'hA5, 8'h00, 1'b0);
    xfer(8'h3C, 8'hA5, 1'b0);
    xfer(8'h5A, 8'h3C, 1'b1);

    // Abort a transaction with rst in SHIFT cycle 5
    start  = 1'b1;
    vec_in = 8'hC3;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      start = 1'b0;
    end
    check_eq("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_stb", ser_stb, 0);
    check_eq("abort_di", ser_di, 0);
    check_eq("abort_vec_out", vec_out, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq($sformatf("abort_idle_stb%0d", k), ser_stb, 0);
      check_eq($sformatf("abort_idle_busy%0d", k), busy, 0);
    end

    // Harness din still holds 8'h5A from the last completed strobe
    xfer(8'h81, 8'h5A, 1'b0);

    roi_inv = 1'b1;
    xfer(8'h0F, 8'h7E, 1'b0);
    xfer(8'h0F, 8'hF0, 1'b0);

    tick();
    check_eq("final_done_low", done, 0);
    check_eq("final_vec_out_hold", vec_out, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
